counter_seq: RTL and testbench

COUNTER_SEQ -- requirements
Module: counter_seq

---
 rtl/counter_pkg.sv | 19 +
 rtl/counter_seq.sv | 117 +++++++++++
 tb/tb_counter_seq.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/counter_pkg.sv
// Shared definitions for the counter family: default geometry and the
// terminal-count compare used by both the free-running counter and the
// start/stop sequencer built on top of it.
package counter_pkg;

  localparam int unsigned DEF_DW  = 8;
  localparam int unsigned DEF_MAX = 8'h3F;

  // Widest legal counter; compares are done at this width so one helper
  // serves every DW.
  localparam int unsigned CMP_W = 16;

  // True when a count value sits on the terminal count.
  function automatic logic is_terminal(input logic [CMP_W-1:0] value,
                                       input logic [CMP_W-1:0] max_v);
    return value == max_v;
  endfunction

endpackage

// File: rtl/counter_seq.sv
// counter    : free-running, enable-driven wrap counter with a decoded
//              terminal level.
// counter_seq: one-shot run sequencer. A start request clears the count and
//              arms a run; the run counts 0..MAX, then emits a single
//              registered strb pulse and returns to idle at zero.

module counter
  import counter_pkg::*;
#(
  parameter int unsigned DW  = DEF_DW,
  parameter int unsigned MAX = DEF_MAX
) (
  input  logic          sdc_clk,
  input  logic          reset,
  input  logic          enable,
  output logic [DW-1:0] cntr,
  output logic          strb
);

  // NOTE: the declaration initialiser gives the register its reset value at
  // power-up as well, so the first cycles before reset are already defined.
  logic [DW-1:0] cntr_q = '0;
  logic [DW-1:0] cntr_d;
  logic          at_max;

  assign at_max = is_terminal(CMP_W'(cntr_q), CMP_W'(MAX));

  // Next count: hold, increment, or wrap to zero on the terminal count.
  always_comb begin
    // NOTE: default first so every path assigns cntr_d and no latch is inferred.
    cntr_d = cntr_q;
    if (enable) begin
      cntr_d = at_max ? '0 : cntr_q + DW'(1);
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge sdc_clk) begin
    // NOTE: non-blocking so every register samples pre-edge values.
    if (reset) cntr_q <= '0;
    else       cntr_q <= cntr_d;
  end

  assign cntr = cntr_q;
  // Level, decoded from the registered count: high for the whole MAX cycle.
  assign strb = at_max;

endmodule

module counter_seq
  import counter_pkg::*;
#(
  parameter int unsigned DW  = DEF_DW,
  parameter int unsigned MAX = DEF_MAX
) (
  input  logic          sdc_clk,
  input  logic          reset,
  input  logic          enable,
  input  logic          start_strb,
  output logic [DW-1:0] cntr,
  output logic          strb
);

  logic running_q = 1'b0;
  logic running_d;
  logic strb_q    = 1'b0;
  logic strb_d;

  logic          cnt_reset;
  logic          cnt_enable;
  logic          cnt_at_max;
  logic [DW-1:0] cnt_value;
  logic          terminal;

  // A start simply clears the inner counter; it outranks the terminal wrap,
  // so a start on the terminal cycle restarts the run without a pulse.
  assign cnt_reset  = reset | start_strb;
  // The inner counter only advances inside a run, and freezes while enable
  // is low. Its own wrap at MAX brings the count back to zero at the end.
  assign cnt_enable = running_q & enable;

  counter #(
    .DW  (DW),
    .MAX (MAX)
  ) u_counter (
    .sdc_clk (sdc_clk),
    .reset   (cnt_reset),
    .enable  (cnt_enable),
    .cntr    (cnt_value),
    .strb    (cnt_at_max)
  );

  assign terminal = cnt_enable & ~start_strb & cnt_at_max;

  // Run flag and terminal pulse: start arms, terminal disarms and pulses.
  always_comb begin
    running_d = running_q;
    strb_d    = terminal;
    if (start_strb)    running_d = 1'b1;
    else if (terminal) running_d = 1'b0;
  end

  // Sequencer state; reset overrides start and enable.
  always_ff @(posedge sdc_clk) begin
    if (reset) begin
      running_q <= 1'b0;
      strb_q    <= 1'b0;
    end else begin
      running_q <= running_d;
      strb_q    <= strb_d;
    end
  end

  assign cntr = cnt_value;
  assign strb = strb_q;

endmodule

// File: tb/tb_counter_seq.sv
// Self-checking bench for counter_seq (three geometries) and its counter
// sub-module. Expected values come from a hand-written vector table and a
// small behavioural model; both feed a scoreboard queue that is drained as
// the DUT outputs are sampled one time unit after each rising edge.
module tb_counter_seq;

  logic sdc_clk = 1'b0;
  always #5 sdc_clk = ~sdc_clk;

  int total = 0;
  int bad   = 0;

  typedef struct { int cntr; int running; int strb; } mstate_t;
  typedef struct { int cntr; int strb; } exp_t;
  typedef struct { int rst; int en; int st; int cntr; int strb; } vec_t;

  exp_t sb_a[$];
  exp_t sb_c[$];
  vec_t vecs[$];

  // Instance A: DW=6, MAX=62, with optional strb->start feedback
  logic       a_rst = 1'b1, a_en = 1'b0, a_st_drv = 1'b0, a_fb = 1'b0;
  logic       a_st, a_strb;
  logic [5:0] a_cntr;
  assign a_st = a_st_drv | (a_fb & a_strb);
  counter_seq #(.DW(6), .MAX(6'h3E)) u_a (
    .sdc_clk(sdc_clk), .reset(a_rst), .enable(a_en), .start_strb(a_st),
    .cntr(a_cntr), .strb(a_strb));

  // Instance B: DW=5, MAX=16
  logic       b_rst = 1'b1, b_en = 1'b0, b_st = 1'b0, b_strb;
  logic [4:0] b_cntr;
  counter_seq #(.DW(5), .MAX(5'h10)) u_b (
    .sdc_clk(sdc_clk), .reset(b_rst), .enable(b_en), .start_strb(b_st),
    .cntr(b_cntr), .strb(b_strb));

  // Instance C: DW=4, MAX=3, driven from the vector table
  logic       c_rst = 1'b1, c_en = 1'b0, c_st = 1'b0, c_strb;
  logic [3:0] c_cntr;
  counter_seq #(.DW(4), .MAX(4'h3)) u_c (
    .sdc_clk(sdc_clk), .reset(c_rst), .enable(c_en), .start_strb(c_st),
    .cntr(c_cntr), .strb(c_strb));

  // Instance D: bare counter, DW=8, MAX=0x40
  logic       d_rst = 1'b1, d_en = 1'b0, d_strb;
  logic [7:0] d_cntr;
  counter #(.DW(8), .MAX(8'h40)) u_d (
    .sdc_clk(sdc_clk), .reset(d_rst), .enable(d_en),
    .cntr(d_cntr), .strb(d_strb));

  mstate_t ma = '{0, 0, 0};

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Behavioural next state of the sequencer, written from the requirements.
  function automatic mstate_t model_next(input mstate_t s, input int rst,
                                         input int en, input int st,
                                         input int max);
    mstate_t n;
    n      = s;
    n.strb = 0;
    if (rst != 0) begin
      n = '{0, 0, 0};
    end else if (st != 0) begin
      n.cntr    = 0;
      n.running = 1;
    end else if (s.running != 0 && en != 0) begin
      if (s.cntr < max) begin
        n.cntr = s.cntr + 1;
      end else begin
        n.cntr    = 0;
        n.running = 0;
        n.strb    = 1;
      end
    end
    return n;
  endfunction

  task automatic a_cycle(input int rst, input int en, input int st);
    exp_t e;
    int   st_eff;
    st_eff = ((st != 0) || (a_fb && ma.strb != 0)) ? 1 : 0;
    ma = model_next(ma, rst, en, st_eff, 62);
    sb_a.push_back('{ma.cntr, ma.strb});
    a_rst    = (rst != 0);
    a_en     = (en != 0);
    a_st_drv = (st != 0);
    @(posedge sdc_clk); #1;
    e = sb_a.pop_front();
    check("a_cntr", int'(a_cntr), e.cntr);
    check("a_strb", int'(a_strb), e.strb);
  endtask

  task automatic b_cycle(input int rst, input int en, input int st);
    b_rst = (rst != 0);
    b_en  = (en != 0);
    b_st  = (st != 0);
    @(posedge sdc_clk); #1;
  endtask

  task automatic d_cycle(input int rst, input int en);
    d_rst = (rst != 0);
    d_en  = (en != 0);
    @(posedge sdc_clk); #1;
  endtask

  task automatic add_vec(input int r, input int e, input int s,
                         input int c, input int sb);
    vecs.push_back('{r, e, s, c, sb});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int   first;
    int   last;
    int   pulses;
    exp_t e;

    // ---------------- Table-driven run on instance C (MAX=3) ----------------
    //      rst en st  cntr strb
    add_vec(1, 1, 0,   0,  0);  // reset
    add_vec(0, 1, 0,   0,  0);  // idle, no start
    add_vec(0, 1, 1,   0,  0);  // start
    add_vec(0, 1, 0,   1,  0);
    add_vec(0, 1, 0,   2,  0);
    add_vec(0, 1, 0,   3,  0);  // at MAX
    add_vec(0, 1, 0,   0,  1);  // terminal pulse
    add_vec(0, 1, 0,   0,  0);  // idle holds zero
    add_vec(0, 1, 1,   0,  0);  // start
    add_vec(0, 0, 0,   0,  0);  // stalled
    add_vec(0, 1, 0,   1,  0);
    add_vec(0, 1, 0,   2,  0);
    add_vec(0, 0, 0,   2,  0);  // stalled mid-run
    add_vec(0, 1, 0,   3,  0);
    add_vec(0, 1, 1,   0,  0);  // start on terminal cycle: start wins
    add_vec(0, 1, 0,   1,  0);  // run continues
    add_vec(1, 1, 1,   0,  0);  // reset beats start
    add_vec(0, 1, 0,   0,  0);  // no run after reset
    add_vec(0, 0, 1,   0,  0);  // start regardless of enable
    add_vec(0, 1, 0,   1,  0);
    add_vec(0, 1, 0,   2,  0);
    add_vec(0, 1, 0,   3,  0);
    add_vec(0, 0, 0,   3,  0);  // stalled at MAX: no pulse
    add_vec(0, 1, 0,   0,  1);  // terminal after resume

    for (int i = 0; i < vecs.size(); i++) begin
      sb_c.push_back('{vecs[i].cntr, vecs[i].strb});
      c_rst = (vecs[i].rst != 0);
      c_en  = (vecs[i].en != 0);
      c_st  = (vecs[i].st != 0);
      @(posedge sdc_clk); #1;
      e = sb_c.pop_front();
      check($sformatf("c_cntr[%0d]", i), int'(c_cntr), e.cntr);
      check($sformatf("c_strb[%0d]", i), int'(c_strb), e.strb);
    end

    // ---------------- Instance A: single run (MAX=62) ----------------
    a_cycle(1, 1, 0);
    check("a_reset_cntr", int'(a_cntr), 0);
    a_cycle(0, 1, 1);
    first = -1;
    for (int k = 1; k <= 70; k++) begin
      a_cycle(0, 1, 0);
      if (k == 62) check("a_peak", int'(a_cntr), 62);
      if (a_strb && first < 0) first = k;
    end
    // Pulse follows the edge that finds the count at MAX: MAX+1 edges on.
    check("a_strb_edge", first, 63);
    check("a_idle_cntr", int'(a_cntr), 0);

    // ---------------- Instance A: strb fed back into start ----------------
    a_fb = 1'b1;
    a_cycle(0, 1, 1);
    last   = -1;
    pulses = 0;
    for (int k = 1; k <= 260; k++) begin
      a_cycle(0, 1, 0);
      if (a_strb) begin
        if (last >= 0) check("a_period", k - last, 64);
        last = k;
        pulses++;
      end
    end
    check("a_pulses", pulses, 4);
    a_fb = 1'b0;

    // ---------------- Instance A: restarts mid-run and on terminal ----------------
    a_cycle(1, 1, 0);
    a_cycle(0, 1, 1);
    for (int k = 0; k < 20; k++) a_cycle(0, 1, 0);
    check("a_at20", int'(a_cntr), 20);
    a_cycle(0, 1, 1);
    check("a_restart20", int'(a_cntr), 0);
    for (int k = 0; k < 62; k++) a_cycle(0, 1, 0);
    check("a_at_max", int'(a_cntr), 62);
    a_cycle(0, 1, 1);
    check("a_term_start_cntr", int'(a_cntr), 0);
    check("a_term_start_strb", int'(a_strb), 0);
    a_cycle(0, 1, 0);
    check("a_continues", int'(a_cntr), 1);

    // ---------------- Instance A: reset mid-run ----------------
    for (int k = 0; k < 29; k++) a_cycle(0, 1, 0);
    check("a_at30", int'(a_cntr), 30);
    a_cycle(1, 1, 0);
    check("a_rst_cntr", int'(a_cntr), 0);
    check("a_rst_strb", int'(a_strb), 0);
    pulses = 0;
    for (int k = 0; k < 80; k++) begin
      a_cycle(0, 1, 0);
      if (a_strb) pulses++;
    end
    check("a_no_pulse_after_reset", pulses, 0);
    check("a_cntr_after_reset", int'(a_cntr), 0);

    // ---------------- Instance B: stall (MAX=16) ----------------
    b_cycle(1, 1, 0);
    check("b_reset_cntr", int'(b_cntr), 0);
    check("b_reset_strb", int'(b_strb), 0);
    b_cycle(0, 1, 1);
    first = -1;
    for (int k = 1; k <= 25; k++) begin
      b_cycle(0, 1, 0);
      if (b_strb && first < 0) first = k;
    end
    check("b_plain_edge", first, 17);

    b_cycle(0, 1, 1);
    for (int k = 1; k <= 7; k++) b_cycle(0, 1, 0);
    check("b_at7", int'(b_cntr), 7);
    for (int k = 8; k <= 12; k++) begin
      b_cycle(0, 0, 0);
      check("b_hold_cntr", int'(b_cntr), 7);
      check("b_hold_strb", int'(b_strb), 0);
    end
    first = -1;
    for (int k = 13; k <= 30; k++) begin
      b_cycle(0, 1, 0);
      if (b_strb && first < 0) first = k;
    end
    check("b_stall_edge", first, 22);

    // ---------------- Instance D: bare counter (MAX=0x40) ----------------
    d_cycle(1, 0);
    check("d_reset_cntr", int'(d_cntr), 0);
    check("d_reset_strb", int'(d_strb), 0);
    d_cycle(0, 0);
    check("d_hold", int'(d_cntr), 0);
    for (int i = 1; i <= 64; i++) begin
      d_cycle(0, 1);
      d_cycle(0, 0);
      if (i == 63) begin
        check("d_at63_cntr", int'(d_cntr), 63);
        check("d_at63_strb", int'(d_strb), 0);
      end
    end
    check("d_at64_cntr", int'(d_cntr), 8'h40);
    check("d_at64_strb", int'(d_strb), 1);
    d_cycle(0, 1);
    check("d_wrap_cntr", int'(d_cntr), 0);
    check("d_wrap_strb", int'(d_strb), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
